// File: rtl/wb_unit_param.sv
// Writeback unit: retires one ALU result or load per cycle into the register file,
// waiting in WAIT for late load data and aborting misaligned, unsupported or timed-out loads.
module wb_unit_param #(
    parameter int XLEN    = 32,
    parameter int IDX_W   = 5,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 32
) (
    input  logic                        clk_i,
    input  logic                        reset_ni,
    input  logic                        mem_valid_i,
    input  logic [IDX_W-1:0]            mem_rd_index_i,
    input  logic                        mem_access_i,
    input  logic [2:0]                  mem_funct3_i,
    input  logic [$clog2(XLEN/8)-1:0]   mem_addr_lo_i,
    input  logic [XLEN-1:0]             mem_alu_result_i,
    input  logic [XLEN-1:0]             mem_rdata_i,
    input  logic                        mem_rdata_valid_i,
    output logic                        wb_ready_o,
    output logic [IDX_W-1:0]            rd_index_o,
    output logic [XLEN-1:0]             rd_value_o,
    output logic                        rd_we_o,
    output logic                        load_err_o,
    output logic [CNT_W-1:0]            retire_count_o
);
    localparam int AL_W = $clog2(XLEN/8);
    localparam int TO_W = $clog2(TIMEOUT + 1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t            state;
    logic [TO_W-1:0]   to_cnt;
    logic [IDX_W-1:0]  lat_idx;
    logic [2:0]        lat_f3;
    logic [AL_W-1:0]   lat_lo;

    logic [2:0]        sel_f3;
    logic [AL_W-1:0]   sel_lo;
    logic [XLEN-1:0]   shifted;
    logic [XLEN-1:0]   ext_value;
    logic              ext_err;
    logic              alu_fire;
    logic              load_fire;
    logic              timeout_hit;
    logic              do_retire;
    logic              do_err;
    logic [IDX_W-1:0]  commit_idx;
    logic [XLEN-1:0]   commit_val;

    assign wb_ready_o = (state == S_IDLE);

    // A pending load uses the fields captured at acceptance, not the live bus.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        sel_f3    = (state == S_WAIT) ? lat_f3 : mem_funct3_i;
        sel_lo    = (state == S_WAIT) ? lat_lo : mem_addr_lo_i;
        shifted   = mem_rdata_i >> {sel_lo, 3'b000};
        ext_value = '0;
        ext_err   = 1'b0;
        case (sel_f3)
            3'b000: ext_value = XLEN'($signed(shifted[7:0]));
            3'b100: ext_value = XLEN'(shifted[7:0]);
            3'b001: begin
                ext_value = XLEN'($signed(shifted[15:0]));
                ext_err   = sel_lo[0];
            end
            3'b101: begin
                ext_value = XLEN'(shifted[15:0]);
                ext_err   = sel_lo[0];
            end
            3'b010: begin
                ext_value = XLEN'($signed(shifted[31:0]));
                ext_err   = (sel_lo[1:0] != 2'b00);
            end
            3'b110: begin
                ext_value = XLEN'(shifted[31:0]);
                ext_err   = (XLEN != 64) || (sel_lo[1:0] != 2'b00);
            end
            3'b011: begin
                ext_value = shifted;
                ext_err   = (XLEN != 64) || (sel_lo != '0);
            end
            default: ext_err = 1'b1;
        endcase
    end

    always_comb begin
        alu_fire    = 1'b0;
        load_fire   = 1'b0;
        timeout_hit = 1'b0;
        if (state == S_IDLE) begin
            if (mem_valid_i && !mem_access_i) alu_fire = 1'b1;
            if (mem_valid_i && mem_access_i && mem_rdata_valid_i) load_fire = 1'b1;
        end else begin
            load_fire   = mem_rdata_valid_i;
            timeout_hit = !mem_rdata_valid_i && (to_cnt == TO_W'(TIMEOUT - 1));
        end
        do_retire  = alu_fire || (load_fire && !ext_err);
        do_err     = (load_fire && ext_err) || timeout_hit;
        commit_idx = (state == S_WAIT) ? lat_idx : mem_rd_index_i;
        commit_val = alu_fire ? mem_alu_result_i : ext_value;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state          <= S_IDLE;
            to_cnt         <= '0;
            lat_idx        <= '0;
            lat_f3         <= '0;
            lat_lo         <= '0;
            rd_index_o     <= '0;
            rd_value_o     <= '0;
            rd_we_o        <= 1'b0;
            load_err_o     <= 1'b0;
            retire_count_o <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            rd_we_o    <= 1'b0;
            load_err_o <= do_err;
            if (do_retire) begin
                retire_count_o <= retire_count_o + CNT_W'(1);
                if (commit_idx != '0) begin
                    rd_we_o    <= 1'b1;
                    rd_index_o <= commit_idx;
                    rd_value_o <= commit_val;
                end
            end
            if (state == S_IDLE) begin
                if (mem_valid_i && mem_access_i && !mem_rdata_valid_i) begin
                    state   <= S_WAIT;
                    to_cnt  <= '0;
                    lat_idx <= mem_rd_index_i;
                    lat_f3  <= mem_funct3_i;
                    lat_lo  <= mem_addr_lo_i;
                end
            end else if (mem_rdata_valid_i || timeout_hit) begin
                state <= S_IDLE;
            end else begin
                to_cnt <= to_cnt + TO_W'(1);
            end
        end
    end
endmodule

// File: doc/wb_unit_param.md
Name: wb_unit_param

Overview:
Parametrised writeback unit for the in-order RISC-V pipeline. It sits between mem_stage and register_file. It accepts one retiring instruction per cycle and waits for load data that arrives late. It extracts and sign- or zero-extends sub-word load data, flags misaligned, unsupported or timed-out loads, and drives the register-file write port for one cycle per retirement.

Parameters:
XLEN, 32, datapath width; legal values are 32 or 64.
IDX_W, 5, register index width.
TIMEOUT, 15, maximum cycles spent in WAIT before a load is aborted; must be at least 1.
CNT_W, 32, width of the retirement counter.

Ports:
clk_i  in  1  clock, rising edge.
reset_ni  in  1  asynchronous active-low reset.
mem_valid_i  in  1  mem_stage presents an instruction this cycle.
mem_rd_index_i  in  IDX_W  destination register index.
mem_access_i  in  1  1 = load, 0 = ALU result.
mem_funct3_i  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; 011 LD and 110 LWU are legal only when XLEN=64.
mem_addr_lo_i  in  log2(XLEN/8)  low address bits of the load.
mem_alu_result_i  in  XLEN  ALU result.
mem_rdata_i  in  XLEN  raw memory read word.
mem_rdata_valid_i  in  1  mem_rdata_i is valid this cycle.
wb_ready_o  out  1  unit can accept an instruction; mem_stage stalls while it is 0.
rd_index_o  out  IDX_W  register-file write index.
rd_value_o  out  XLEN  register-file write data.
rd_we_o  out  1  register-file write enable, one-cycle pulse.
load_err_o  out  1  one-cycle pulse when a load is aborted.
retire_count_o  out  CNT_W  count of completed instructions.

Behaviour:
- Reset is asynchronous. While reset_ni is 0:
  - state = IDLE and the timeout counter = 0.
  - rd_index_o, rd_value_o, rd_we_o, load_err_o and retire_count_o are all 0.
  - Reset taken mid-WAIT abandons the pending load; nothing is written.
- States are IDLE and WAIT. wb_ready_o = (state == IDLE), purely combinational from state.
- IDLE with mem_valid_i = 1, the instruction is accepted:
  - ALU op (mem_access_i = 0): retires next edge with value = mem_alu_result_i.
  - Load with mem_rdata_valid_i = 1 in the same cycle: retires next edge with the extracted value.
  - Load with mem_rdata_valid_i = 0: latch index, funct3 and addr_lo; go to WAIT; clear the timeout counter.
- WAIT:
  - mem_valid_i is ignored (upstream holds its data while wb_ready_o = 0).
  - On mem_rdata_valid_i = 1: retire using the latched fields and go to IDLE.
  - Otherwise the counter increments. When the counter reaches TIMEOUT-1 with no data: pulse load_err_o on the next edge, go to IDLE, no write, no retirement count.
- mem_rdata_valid_i is ignored while IDLE with no load being accepted.
- Load extraction, with byte lane = addr_lo:
  - LB/LBU: byte at lane addr_lo, sign- or zero-extended to XLEN.
  - LH/LHU: halfword starting at byte addr_lo.
  - LW: word; sign-extended when XLEN = 64.
  - LWU: zero-extended word.
  - LD: full 64-bit word.
- Load errors, detected at the point the data would retire (an error in WAIT returns to IDLE immediately):
  - Misalignment: halfword with addr_lo[0] = 1, word with addr_lo[1:0] ≠ 0, or LD with addr_lo ≠ 0.
  - Unsupported funct3 for the configured XLEN.
  - Either case gives load_err_o = 1 for one cycle, no write, no retirement count.
- Retirement takes effect on the edge after the data is available:
  - retire_count_o increments by 1 and wraps modulo 2^CNT_W.
  - If rd index ≠ 0: rd_we_o = 1, rd_index_o = index, rd_value_o = value.
  - If rd index = 0: rd_we_o = 0, but the instruction still counts.
- rd_we_o and load_err_o are 0 in every cycle without such an event.
- rd_index_o and rd_value_o hold their last written values while rd_we_o = 0.
- Total latency is 1 cycle from the data being available to rd_we_o asserting.

Test Plan:
- ALU retire: valid, rd = 5, alu = 0x1234_5678 -> next cycle rd_we_o = 1, rd_index_o = 5, rd_value_o = 0x1234_5678, count = 1.
- x0 target: valid ALU op with rd = 0 -> rd_we_o = 0, index/value unchanged, count increments.
- Late sign-extended load: LB, rd = 3, addr_lo = 2, data valid 3 cycles later with rdata = 0x0080_0000 -> wb_ready_o low for 3 cycles, then rd_value_o = 0xFFFF_FF80, rd_we_o = 1.
- Timeout: TIMEOUT = 4, a load is accepted and data never arrives -> load_err_o pulses one cycle 4 cycles after acceptance, no write, wb_ready_o returns to 1.
- Misaligned load: LH with addr_lo = 1 and data valid -> load_err_o = 1, rd_we_o = 0, count unchanged. LHU with addr_lo = 2 and rdata = 0xBEEF_0000 -> rd_value_o = 0x0000_BEEF.
- Reset in WAIT plus counter wrap: drive reset_ni = 0 mid-WAIT -> all outputs 0 and state IDLE asynchronously. With CNT_W = 2, retire 5 instructions -> retire_count_o = 1.
